sram_like_arbiter: RTL and testbench

- Two-requester arbiter sharing one sram_like memory master port between the instruction-fetch port and the MEM-stage data port.
- Sits between the CPU core and the bridge that converts sram_like to AXI.
- Allows one outstanding transaction at a time.
- Data side has fixed priority, with a starvation limit so that fetch is not locked out.

---
 rtl/sram_like_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-requester sram_like arbiter: instruction fetch and data share one master port,
// one outstanding transaction, data-first priority bounded by a starvation limit.
module sram_like_arbiter #(
    parameter int unsigned DATA_MAX_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic        grant_data,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [3:0] MaxRun = 4'(DATA_MAX_RUN);

    state_e     r_state;
    state_e     w_state_next;
    logic       r_grant_data;
    logic       w_grant_data_next;
    logic [3:0] r_run;
    logic [3:0] w_run_next;
    logic       w_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_grant_data <= 1'b0;
            r_run        <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_grant_data <= w_grant_data_next;
            r_run        <= w_run_next;
        end
    end

    assign w_req = r_grant_data ? data_req : inst_req;

    always_comb begin
        w_state_next      = r_state;
        w_grant_data_next = r_grant_data;
        w_run_next        = r_run;
        m_req             = 1'b0;
        inst_addr_ok      = 1'b0;
        data_addr_ok      = 1'b0;
        inst_data_ok      = 1'b0;
        data_data_ok      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Run only advances while fetch is actually being passed over.
                if (data_req && ((r_run < MaxRun) || !inst_req)) begin
                    w_grant_data_next = 1'b1;
                    w_state_next      = StIssue;
                    if (!inst_req) begin
                        w_run_next = 4'd0;
                    end else if (r_run >= MaxRun) begin
                        w_run_next = MaxRun;
                    end else begin
                        w_run_next = r_run + 4'd1;
                    end
                end else if (inst_req) begin
                    w_grant_data_next = 1'b0;
                    w_run_next        = 4'd0;
                    w_state_next      = StIssue;
                end
            end
            StIssue: begin
                m_req = w_req;
                if (r_grant_data) begin
                    data_addr_ok = m_addr_ok;
                end else begin
                    inst_addr_ok = m_addr_ok;
                end
                // A dropped request before acceptance cancels without a downstream transfer.
                if (!w_req) begin
                    w_state_next = StIdle;
                end else if (m_addr_ok) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_grant_data) begin
                    data_data_ok = m_data_ok;
                end else begin
                    inst_data_ok = m_data_ok;
                end
                if (m_data_ok) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign m_wr       = r_grant_data ? data_wr    : inst_wr;
    assign m_size     = r_grant_data ? data_size  : inst_size;
    assign m_addr     = r_grant_data ? data_addr  : inst_addr;
    assign m_wdata    = r_grant_data ? data_wdata : inst_wdata;
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;
    assign grant_data = r_grant_data;
    assign busy       = (r_state != StIdle);
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter: a transaction-level reference
// predicts grants and responses; a monitor compares them as the DUT presents them.
module tb_sram_like_arbiter;
    localparam int unsigned MaxRun = 4;

    typedef enum {PhIdle, PhIssue, PhWait} ph_e;
    typedef struct {
        logic        side;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        grant_data, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          en_req, allow_cancel, stray_en, mem_hold, force_dok;
    int unsigned p_req;
    ph_e         ph = PhIdle;
    logic        own = 1'b0;
    int unsigned streak = 0;
    txn_t        exp_q[$];
    logic        rsp_q[$];
    logic [31:0] rdq[$];
    logic        grant_log[$];

    sram_like_arbiter #(.DATA_MAX_RUN(MaxRun)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .grant_data(grant_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the port and what each output must be.
    always @(negedge clk) begin
        logic own_req;
        txn_t t;
        if (reset) begin
            chk1("rst_m_req", m_req, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
            chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
            chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
            chk1("rst_data_data_ok", data_data_ok, 1'b0);
            chk1("rst_grant_data", grant_data, 1'b0);
            ph = PhIdle;
            own = 1'b0;
            streak = 0;
            exp_q.delete();
        end else begin
            own_req = own ? data_req : inst_req;
            chk1("busy", busy, ph != PhIdle);
            chk1("m_req", m_req, (ph == PhIssue) && own_req);
            chk1("inst_addr_ok", inst_addr_ok, (ph == PhIssue) && !own && m_addr_ok);
            chk1("data_addr_ok", data_addr_ok, (ph == PhIssue) && own && m_addr_ok);
            chk1("inst_data_ok", inst_data_ok, (ph == PhWait) && !own && m_data_ok);
            chk1("data_data_ok", data_data_ok, (ph == PhWait) && own && m_data_ok);
            if (ph != PhIdle) chk1("grant_data", grant_data, own);
            case (ph)
                PhIdle: begin
                    if (data_req || inst_req) begin
                        if (data_req && (streak < MaxRun || !inst_req)) begin
                            own = 1'b1;
                            streak = inst_req ? streak + 1 : 0;
                            t = '{1'b1, data_wr, data_size, data_addr, data_wdata};
                        end else begin
                            own = 1'b0;
                            streak = 0;
                            t = '{1'b0, inst_wr, inst_size, inst_addr, inst_wdata};
                        end
                        exp_q.push_back(t);
                        ph = PhIssue;
                    end
                end
                PhIssue: begin
                    if (!own_req) begin
                        ph = PhIdle;
                        if (exp_q.size() != 0) t = exp_q.pop_front();
                    end else if (m_addr_ok) begin
                        ph = PhWait;
                    end
                end
                default: if (m_data_ok) ph = PhIdle;
            endcase
        end
    end

    // Monitor: consume expectations when the DUT presents a downstream accept or a response.
    always @(negedge clk) begin
        txn_t        e;
        logic        s;
        logic [31:0] r;
        if (reset) begin
            rsp_q.delete();
            rdq.delete();
        end else begin
            if (m_req && m_addr_ok) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL accept_unexpected: got m_req with addr %08h, expected none",
                             m_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk1("m_side", grant_data, e.side);
                    chk1("m_wr", m_wr, e.wr);
                    chk32("m_size", {30'd0, m_size}, {30'd0, e.size});
                    chk32("m_addr", m_addr, e.addr);
                    chk32("m_wdata", m_wdata, e.wdata);
                    rsp_q.push_back(e.side);
                    grant_log.push_back(grant_data);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                if (rsp_q.size() == 0 || rdq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL resp_unexpected: got data_ok i=%0b d=%0b, expected none",
                             inst_data_ok, data_data_ok);
                end else begin
                    s = rsp_q.pop_front();
                    r = rdq.pop_front();
                    chk1("resp_side", data_data_ok, s);
                    chk32("resp_rdata", s ? data_rdata : inst_rdata, r);
                end
            end
        end
    end

    // Upstream requesters and downstream memory.
    initial begin
        logic        i_acc, d_acc, acc, fired, cancelled;
        int unsigned mem_wait;
        logic        mem_busy;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        mem_busy = 0; mem_wait = 0; fired = 0;
        forever begin
            @(negedge clk);
            i_acc = inst_req && inst_addr_ok;
            d_acc = data_req && data_addr_ok;
            acc   = m_req && m_addr_ok;
            @(posedge clk);
            #1;
            if (reset) begin
                inst_req = 0;
                data_req = 0;
                mem_busy = 0;
                mem_wait = 0;
                fired    = 0;
                m_addr_ok = 0;
                m_data_ok = force_dok;
            end else begin
                cancelled = 0;
                if (i_acc) inst_req = 0;
                if (d_acc) data_req = 0;
                else if (data_req && allow_cancel && $urandom_range(0, 9) == 0) begin
                    data_req = 0;
                    cancelled = 1;
                end
                if (!inst_req && en_req && $urandom_range(0, 99) < p_req) begin
                    inst_req = 1;
                    inst_wr = 1'($urandom_range(0, 1));
                    inst_size = 2'($urandom_range(0, 2));
                    inst_addr = $urandom();
                    inst_wdata = $urandom();
                end
                if (!data_req && !cancelled && en_req && $urandom_range(0, 99) < p_req) begin
                    data_req = 1;
                    data_wr = 1'($urandom_range(0, 1));
                    data_size = 2'($urandom_range(0, 2));
                    data_addr = $urandom();
                    data_wdata = $urandom();
                end
                if (fired) mem_busy = 0;
                if (acc) begin
                    mem_busy = 1;
                    mem_wait = $urandom_range(0, 2);
                end else if (mem_busy && mem_wait != 0) begin
                    mem_wait--;
                end
                fired = mem_busy && mem_wait == 0 && !mem_hold;
                m_rdata = $urandom();
                if (fired) rdq.push_back(m_rdata);
                m_data_ok = fired || force_dok ||
                            (!mem_busy && stray_en && $urandom_range(0, 5) == 0);
                m_addr_ok = ($urandom_range(0, 99) < 40);
            end
        end
    end

    initial begin
        bit found;
        reset = 1; en_req = 0; p_req = 30; allow_cancel = 0; stray_en = 0;
        mem_hold = 0; force_dok = 0;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        en_req = 1; allow_cancel = 1; stray_en = 1;
        repeat (1500) @(posedge clk);

        // Reset while a transaction waits for data, then a late data_ok.
        mem_hold = 1; allow_cancel = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (ph == PhWait) begin
                found = 1;
                break;
            end
        end
        chk1("reach_wait", found, 1'b1);
        #2 reset = 1; force_dok = 1; en_req = 0;
        @(posedge clk);
        #2 reset = 0;
        repeat (4) @(posedge clk);
        #2 force_dok = 0; mem_hold = 0;

        // Both sides saturated from a fresh reset: starvation limit governs the order.
        @(posedge clk);
        #2 reset = 1; p_req = 100; en_req = 1; stray_en = 0;
        @(posedge clk);
        #2 reset = 0; grant_log.delete();
        for (int i = 0; i < 400 && grant_log.size() < 10; i++) @(posedge clk);
        chk32("starve_count", grant_log.size() >= 10 ? 32'd10 : grant_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk1($sformatf("starve_grant_%0d", i), grant_log[i], (i % (MaxRun + 1)) != MaxRun);

        p_req = 50; allow_cancel = 1; stray_en = 1;
        repeat (1000) @(posedge clk);

        en_req = 0; allow_cancel = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (ph == PhIdle && !inst_req && !data_req) break;
        end
        repeat (2) @(posedge clk);
        chk32("drain_exp_q", exp_q.size(), 32'd0);
        chk32("drain_rsp_q", rsp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
